// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample sample points and default rates.
package uart_pkg;

    localparam int unsigned DEFAULT_CLOCK_RATE = 25_000_000;
    localparam int unsigned DEFAULT_BAUD_RATE  = 115_200;

    localparam int unsigned SAMPLE_CNT_W = 4;
    localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_FIRST = SAMPLE_CNT_W'(7);
    localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_MID   = SAMPLE_CNT_W'(8);
    localparam logic [SAMPLE_CNT_W-1:0] SAMPLE_LAST  = SAMPLE_CNT_W'(9);
    localparam logic [SAMPLE_CNT_W-1:0] BIT_END      = SAMPLE_CNT_W'(15);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_HIGH
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Fractional-accumulator oversample tick generator, shared by the UART RX and TX paths.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = DEFAULT_CLOCK_RATE,
    parameter int unsigned BAUD_RATE  = DEFAULT_BAUD_RATE,
    parameter int unsigned OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned ACC_W = 32;
    localparam logic [ACC_W-1:0] INC   = ACC_W'(BAUD_RATE * OVERSAMPLE);
    localparam logic [ACC_W-1:0] LIMIT = ACC_W'(CLOCK_RATE);

    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] acc_sum;

    assign acc_sum = acc + INC;

    // Clearing restarts the phase so the first tick lands a fixed time after the start edge.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            acc  <= '0;
            tick <= 1'b0;
        end else if (acc_sum >= LIMIT) begin
            acc  <= acc_sum - LIMIT;
            tick <= 1'b1;
        end else begin
            acc  <= acc_sum;
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_rx_frame.sv
// UART frame receiver with 16x oversampling and 3-sample majority voting.
// Define UART_RX_PARITY_EN to expect a parity bit between data and stop.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE    = DEFAULT_CLOCK_RATE,
    parameter int unsigned BAUD_RATE     = DEFAULT_BAUD_RATE,
    parameter int unsigned RX_OVERSAMPLE = 16
`ifdef UART_RX_PARITY_EN
    ,
    parameter bit          PARITY_ODD    = 1'b0
`endif
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_Rx_Data,
    output logic [7:0] o_Rx_Byte,
    output logic       o_Rx_Done,
    output logic       o_Rx_Active,
    output logic       o_Rx_Frame_Err,
    output logic       o_Rx_Parity_Err
);

    logic                    rx_meta;
    logic                    rx_sync;
    logic                    rx_prev;
    logic                    start_edge;
    logic                    tick;
    logic                    bit_val;
    rx_state_t               state;
    logic [SAMPLE_CNT_W-1:0] sample_cnt;
    logic [SAMPLE_CNT_W-1:0] cnt_next;
    logic [2:0]              bit_idx;
    logic [7:0]              shift;
    logic                    samp_a;
    logic                    samp_b;
`ifdef UART_RX_PARITY_EN
    logic                    parity_err;
`endif

    // Two-flop synchronizer plus edge flop; idle-high reset avoids a false start.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= i_Rx_Data;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign start_edge = (state == ST_IDLE) && rx_prev && !rx_sync;
    assign cnt_next   = sample_cnt + SAMPLE_CNT_W'(1);
    assign bit_val    = majority3(samp_a, samp_b, rx_sync);

    uart_baud_tick #(
        .CLOCK_RATE (CLOCK_RATE),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (RX_OVERSAMPLE)
    ) u_baud_tick (
        .clk   (clk),
        .reset (reset),
        .clear (start_edge),
        .tick  (tick)
    );

    // Sample points and transitions key off the tick that moves the counter onto a value.
    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            sample_cnt     <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            samp_a         <= 1'b1;
            samp_b         <= 1'b1;
            o_Rx_Byte      <= '0;
            o_Rx_Done      <= 1'b0;
            o_Rx_Active    <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err      <= 1'b0;
            o_Rx_Parity_Err <= 1'b0;
`endif
        end else begin
            o_Rx_Done      <= 1'b0;
            o_Rx_Frame_Err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            o_Rx_Parity_Err <= 1'b0;
`endif
            if (tick) begin
                sample_cnt <= cnt_next;
                if (cnt_next == SAMPLE_FIRST) samp_a <= rx_sync;
                if (cnt_next == SAMPLE_MID)   samp_b <= rx_sync;
            end

            case (state)
                ST_IDLE: begin
                    if (start_edge) begin
                        state       <= ST_START;
                        sample_cnt  <= '0;
                        bit_idx     <= '0;
                        o_Rx_Active <= 1'b1;
                    end
                end
                ST_START: begin
                    if (tick && cnt_next == SAMPLE_LAST && bit_val) begin
                        state       <= ST_IDLE;
                        o_Rx_Active <= 1'b0;
                    end else if (tick && cnt_next == BIT_END) begin
                        state <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick && cnt_next == SAMPLE_LAST) shift <= {bit_val, shift[7:1]};
                    if (tick && cnt_next == BIT_END) begin
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                            state <= ST_PARITY;
`else
                            state <= ST_STOP;
`endif
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (tick && cnt_next == SAMPLE_LAST) parity_err <= bit_val ^ (^shift) ^ PARITY_ODD;
                    if (tick && cnt_next == BIT_END) state <= ST_STOP;
                end
`endif
                ST_STOP: begin
                    // Leave at mid-stop so a back-to-back start edge is not missed.
                    if (tick && cnt_next == SAMPLE_LAST) begin
                        o_Rx_Active <= 1'b0;
                        if (bit_val) begin
                            o_Rx_Byte <= shift;
                            o_Rx_Done <= 1'b1;
`ifdef UART_RX_PARITY_EN
                            o_Rx_Parity_Err <= parity_err;
`endif
                            state <= ST_IDLE;
                        end else begin
                            o_Rx_Frame_Err <= 1'b1;
                            state          <= ST_WAIT_HIGH;
                        end
                    end
                end
                ST_WAIT_HIGH: begin
                    if (rx_sync) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign o_Rx_Parity_Err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_frame.sv
// Scoreboard bench for uart_rx_frame: directed and random frames at 217 clk/bit.
module tb_uart_rx_frame;

    localparam int CLKS_PER_BIT = 217;
`ifdef UART_RX_PARITY_EN
    localparam bit PARITY_ON = 1'b1;
`else
    localparam bit PARITY_ON = 1'b0;
`endif
    // Start-edge-to-Done: ~9.6 bit periods (one more bit with parity), sync latency and one tick of slack.
    localparam int LAT_NOM = 2083 + (PARITY_ON ? CLKS_PER_BIT : 0);
    localparam int LAT_TOL = 20;
    localparam int MAX_CYC = 95000;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic       rx    = 1'b1;
    logic [7:0] o_Rx_Byte;
    logic       o_Rx_Done;
    logic       o_Rx_Active;
    logic       o_Rx_Frame_Err;
    logic       o_Rx_Parity_Err;

    int         cyc    = 0;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] hold_byte = 8'h00;

    typedef struct {
        bit         is_ferr;
        logic [7:0] data;
        bit         par_err;
        int         start;
    } exp_t;
    exp_t exp_q[$];

    uart_rx_frame dut (
        .clk             (clk),
        .reset           (reset),
        .i_Rx_Data       (rx),
        .o_Rx_Byte       (o_Rx_Byte),
        .o_Rx_Done       (o_Rx_Done),
        .o_Rx_Active     (o_Rx_Active),
        .o_Rx_Frame_Err  (o_Rx_Frame_Err),
        .o_Rx_Parity_Err (o_Rx_Parity_Err)
    );

    always #20 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h) at cycle %0d", name, act, act, req, req, cyc);
        end
    endtask

    task automatic drive(input logic v, input int n);
        rx = v;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par_flip);
        exp_t e;
        e.is_ferr = !stop_ok;
        e.data    = d;
        e.par_err = PARITY_ON && stop_ok && par_flip;
        e.start   = cyc;
        exp_q.push_back(e);
        drive(1'b0, CLKS_PER_BIT);
        drive(d[0], CLKS_PER_BIT / 2);
        check(o_Rx_Active == 1'b1, "active_mid_frame", int'(o_Rx_Active), 1);
        drive(d[0], CLKS_PER_BIT - CLKS_PER_BIT / 2);
        for (int i = 1; i < 8; i++) drive(d[i], CLKS_PER_BIT);
        if (PARITY_ON) drive((^d) ^ par_flip, CLKS_PER_BIT);
        drive(stop_ok, CLKS_PER_BIT);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check(exp_q.size() == 0, name, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic pulse_reset();
        reset     = 1'b1;
        hold_byte = 8'h00;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic check_reset(input string tag);
        check(o_Rx_Byte == 8'h00,      {tag, "_byte"},   int'(o_Rx_Byte), 0);
        check(o_Rx_Done == 1'b0,       {tag, "_done"},   int'(o_Rx_Done), 0);
        check(o_Rx_Active == 1'b0,     {tag, "_active"}, int'(o_Rx_Active), 0);
        check(o_Rx_Frame_Err == 1'b0,  {tag, "_ferr"},   int'(o_Rx_Frame_Err), 0);
        check(o_Rx_Parity_Err == 1'b0, {tag, "_perr"},   int'(o_Rx_Parity_Err), 0);
    endtask

    // Monitor: every output pulse is matched against the oldest expected frame outcome.
    initial begin : monitor
        exp_t e;
        int   lat;
        forever begin
            @(negedge clk);
            if (cyc > MAX_CYC) begin
                $display("FAIL watchdog: cycle %0d, required below %0d", cyc, MAX_CYC);
                $fatal(1, "watchdog expired");
            end
            if (!reset && (o_Rx_Done || o_Rx_Frame_Err || o_Rx_Parity_Err)) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pulse: done=%0b ferr=%0b perr=%0b byte=%02h, required no pulse at cycle %0d",
                             o_Rx_Done, o_Rx_Frame_Err, o_Rx_Parity_Err, o_Rx_Byte, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check(o_Rx_Done == !e.is_ferr, "done_pulse", int'(o_Rx_Done), int'(!e.is_ferr));
                    check(o_Rx_Frame_Err == e.is_ferr, "frame_err_pulse", int'(o_Rx_Frame_Err), int'(e.is_ferr));
                    check(o_Rx_Parity_Err == e.par_err, "parity_err_pulse", int'(o_Rx_Parity_Err), int'(e.par_err));
                    check(o_Rx_Active == 1'b0, "active_fall", int'(o_Rx_Active), 0);
                    lat = cyc - e.start;
                    check(lat >= LAT_NOM - LAT_TOL && lat <= LAT_NOM + LAT_TOL, "latency", lat, LAT_NOM);
                    if (!e.is_ferr) hold_byte = e.data;
                    check(o_Rx_Byte == hold_byte, e.is_ferr ? "byte_hold" : "rx_byte", int'(o_Rx_Byte), int'(hold_byte));
                end
            end
        end
    end

    initial begin : stim
        logic [7:0] b2b [4];
        logic [7:0] aa;
        logic [7:0] rd;
        bit         good;
        bit         flip;
        bit         seen;
        int         n;

        b2b = '{8'h01, 8'h10, 8'h22, 8'hFF};
        aa  = 8'hAA;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_reset("reset");

        send_frame(8'h55, 1'b1, 1'b0);
        drain("drain_55");

        foreach (b2b[i]) send_frame(b2b[i], 1'b1, 1'b0);
        drain("drain_b2b");

        // 3-clk glitch on an idle line must be rejected at mid-start.
        seen = 1'b0;
        rx   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 2) rx = 1'b1;
            if (o_Rx_Active) seen = 1'b1;
        end
        check(seen, "glitch_active_rise", int'(seen), 1);
        n = 0;
        while (o_Rx_Active && n < 400) begin
            @(negedge clk);
            n++;
        end
        check(o_Rx_Active == 1'b0, "glitch_active_fall", int'(o_Rx_Active), 0);
        drive(1'b1, 50);
        send_frame(8'hA5, 1'b1, 1'b0);
        drain("drain_a5");

        pulse_reset();
        check_reset("reset2");
        send_frame(8'h3C, 1'b0, 1'b0);
        drive(1'b0, 2 * CLKS_PER_BIT);
        drive(1'b1, CLKS_PER_BIT);
        send_frame(8'h7E, 1'b1, 1'b0);
        drain("drain_ferr");
        check(o_Rx_Byte == 8'h7E, "byte_after_ferr", int'(o_Rx_Byte), 8'h7E);

        // Abort 0xAA mid data bit 4 with a one-cycle reset.
        drive(1'b0, CLKS_PER_BIT);
        for (int i = 0; i < 4; i++) drive(aa[i], CLKS_PER_BIT);
        drive(aa[4], CLKS_PER_BIT / 2);
        rx = 1'b1;
        pulse_reset();
        check_reset("reset_mid_frame");
        drive(1'b1, 400);
        check_reset("after_abort");
        send_frame(8'h0B, 1'b1, 1'b0);
        drain("drain_0b");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b0);
        drain("drain_par_ok");
        send_frame(8'h07, 1'b1, 1'b1);
        drain("drain_par_bad");
`endif

        for (int k = 0; k < 12; k++) begin
            rd   = 8'($urandom);
            good = ($urandom_range(0, 5) != 0);
            flip = 1'($urandom_range(0, 1));
            drive(1'b1, int'($urandom_range(0, 300)));
            send_frame(rd, good, flip);
            if (!good) begin
                drive(1'b0, CLKS_PER_BIT);
                drive(1'b1, CLKS_PER_BIT);
            end
        end
        drain("drain_random");
        drive(1'b1, 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Standalone UART receiver: recovers 8-bit frames (1 start, 8 data LSB-first, optional parity, 1 stop) from an asynchronous serial line using 16x oversampling with majority voting. It is the receive end for serial traffic produced by the existing UART transmit path. It sits between the board RX pin and the byte-consumer logic, and reports framing and parity errors.

## Interface
- `CLOCK_RATE`, 25000000, system clock frequency in Hz.
- `BAUD_RATE`, 115200, line rate in bit/s.
- `RX_OVERSAMPLE`, 16, oversample ticks per bit; fixed legal value is 16.
- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_Rx_Data`  in  1  asynchronous serial line, idle high.
- `o_Rx_Byte`  out  8  last good received byte; holds until the next good frame.
- `o_Rx_Done`  out  1  one-cycle pulse; `o_Rx_Byte` is valid in the same cycle.
- `o_Rx_Active`  out  1  high from start-edge detection until return to IDLE.
- `o_Rx_Frame_Err`  out  1  one-cycle pulse when the stop bit samples low.
- `o_Rx_Parity_Err`  out  1  one-cycle pulse on parity mismatch; tied 0 when parity is not compiled in.

## Operation
- Input sync: 2-flop synchronizer on `i_Rx_Data`, plus one extra flop used for falling-edge detection. Both synchronizer flops reset to 1.
- Tick generator: fractional accumulator, 32-bit.
  - Each clk, add `BAUD_RATE*RX_OVERSAMPLE`.
  - When the sum is >= `CLOCK_RATE`, subtract `CLOCK_RATE` and assert `tick` for one cycle.
  - The accumulator clears to 0 on start-edge detection, so sampling phase is aligned to the edge.
- Sample counter: 4-bit, counts ticks 0..15 within a bit and wraps.
  - Samples are taken at counts 7, 8 and 9. Bit value is the majority of these three.
  - The bit decision is applied on count 9.
  - Bit end is count 15.
- States:
  - IDLE: synchronized line falls from 1 to 0 -> START. Counters clear.
  - START: at count 9, majority=1 (glitch) -> IDLE with no outputs; majority=0 -> at count 15, go to DATA.
  - DATA: shift the majority bit into bit 7 of the shift register (LSB arrives first). After the 8th bit's count 15 -> PARITY if enabled, else STOP.
  - PARITY: at count 9, store the parity check result. At count 15 -> STOP.
  - STOP: at count 9, act on the majority value:
    - Majority=1: load `o_Rx_Byte`, pulse `o_Rx_Done`, go to IDLE. Do not wait for count 15; this allows back-to-back frames.
    - Majority=0: pulse `o_Rx_Frame_Err`, leave `o_Rx_Byte` unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: remain until the synchronized line is 1, then go to IDLE. This covers break conditions and prevents false restarts.
- Parity error: when the parity error is set and the stop bit is good, `o_Rx_Parity_Err` pulses in the same cycle as `o_Rx_Done`, and the byte is still delivered.
- Reset at any point: state IDLE, counters 0, shift register 0. Any frame in flight is discarded with no pulses.

## Timing
- Values after reset: `o_Rx_Byte`=8'h00, `o_Rx_Done`=0, `o_Rx_Active`=0, `o_Rx_Frame_Err`=0, `o_Rx_Parity_Err`=0.
- Edge detection latency is 3 clk from the pin transition: 2 sync flops plus the edge flop.
- `o_Rx_Active` rises in the cycle after the edge is detected.
- `o_Rx_Done` is registered and asserts 1 clk after the tick at stop-bit count 9.
  - Without parity: about 9.6 bit periods after the start edge.
  - At defaults: about 2083 clk, ±1 tick (14 clk).
- `o_Rx_Active` falls in the same cycle that `o_Rx_Done` or `o_Rx_Frame_Err` asserts. For a rejected glitch, it falls after START count 9.
- Pulses are exactly 1 clk wide. There is no backpressure; a consumer that misses the pulse loses the byte.
- A new start edge is accepted in the cycle after the return to IDLE.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state exists and one parity bit is expected between data and stop.
  - Parameter `PARITY_ODD` (default 0, meaning even parity) selects the sense.
  - `o_Rx_Parity_Err` is driven.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state; the frame is 10 bits.
  - `o_Rx_Parity_Err` is tied to 0.

## Structure
- Package `uart_pkg` holds:
  - the state encoding (IDLE, START, DATA, PARITY, STOP, WAIT_HIGH);
  - the sample-point constants (7/8/9, end count 15);
  - the default `CLOCK_RATE`/`BAUD_RATE`.
- Sub-module `uart_baud_tick` contains the fractional accumulator. It has inputs `clk`, `reset`, `clear`, and output `tick`. The same sub-module is reused by the TX side.

## Test plan
- Reset, then drive 0x55 at 115200 baud (217 clk/bit, 40 ns clk) -> one `o_Rx_Done` pulse, `o_Rx_Byte`=8'h55, no error pulses.
- Back-to-back frames 0x01, 0x10, 0x22, 0xFF with no idle gap -> four Done pulses, bytes received in order, no errors.
- 3-clk low glitch on an idle line -> `o_Rx_Active` pulses briefly, no Done, state returns to IDLE, and a following 0xA5 frame is received correctly.
- Frame 0x3C with stop bit driven low, line held low for 2 bit times, then 0x7E -> `o_Rx_Frame_Err` pulses once, `o_Rx_Byte` stays 8'h00, then 0x7E is received.
- Assert `reset` for 1 clk midway through data bit 4 of 0xAA -> no pulses, all outputs at reset values, next frame 0x0B received correctly.
- With `UART_RX_PARITY_EN` (even parity): send 0x07 with parity bit 1 -> Done with 8'h07; send 0x07 with parity bit 0 -> Done and `o_Rx_Parity_Err` in the same cycle.
